// File: rtl/gpu_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : gpu_prog_loader
// Brief    : Streams a shader program into BANKS instruction RAMs over valid/ready,
//            with bank masking, optional tail zero-fill, checksum and error reporting.
// Revision : 1.0
// ============================================================================
module gpu_prog_loader #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int BANKS  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   length,
    input  logic [BANKS-1:0]  bank_mask,
    input  logic              clear_tail,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [BANKS-1:0]  mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              prog_loading,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CLEAR = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [ADDR_W:0] C_DEPTH = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] C_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] C_LAST  = C_DEPTH - C_ONE;

    logic [2:0]        r_state;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_cnt;
    logic [BANKS-1:0]  r_mask;
    logic              r_clear_tail;
    logic              r_in_ready;
    logic              r_loading;
    logic              r_done;
    logic              r_error;
    logic [DATA_W-1:0] r_checksum;
    logic [BANKS-1:0]  r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic [2:0] w_next;
    logic       w_accept;
    logic       w_start_bad;
    logic       w_last_beat;
    logic       w_clear_last;

    // abort wins over a beat presented in the same cycle
    assign w_accept     = r_in_ready && in_valid && !abort;
    assign w_start_bad  = (length == '0) || (length > C_DEPTH) || (bank_mask == '0);
    assign w_last_beat  = (r_cnt == (r_len - C_ONE));
    assign w_clear_last = (r_cnt == C_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_start_bad ? S_ERR : S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_accept && w_last_beat) begin
                    w_next = (r_clear_tail && (r_len < C_DEPTH)) ? S_CLEAR : S_DONE;
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_clear_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Memory-side outputs (writes, prog_loading, done) trail the FSM by one register stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_cnt        <= '0;
            r_mask       <= '0;
            r_clear_tail <= 1'b0;
            r_in_ready   <= 1'b0;
            r_loading    <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_checksum   <= '0;
            r_we         <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next == S_LOAD);
            r_loading  <= (r_state == S_LOAD) || (r_state == S_CLEAR) || (r_state == S_DONE);
            r_done     <= (r_state == S_DONE);
            r_we       <= '0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len        <= length;
                        r_mask       <= bank_mask;
                        r_clear_tail <= clear_tail;
                        r_cnt        <= '0;
                        r_checksum   <= '0;
                        r_error      <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        r_error <= 1'b1;
                    end else if (w_accept) begin
                        r_we       <= r_mask;
                        r_addr     <= r_cnt[ADDR_W-1:0];
                        r_wdata    <= in_data;
                        r_checksum <= r_checksum + in_data;
                        r_cnt      <= r_cnt + C_ONE;
                    end
                end
                S_CLEAR: begin
                    if (abort) begin
                        r_error <= 1'b1;
                    end else begin
                        r_we    <= r_mask;
                        r_addr  <= r_cnt[ADDR_W-1:0];
                        r_wdata <= '0;
                        r_cnt   <= r_cnt + C_ONE;
                    end
                end
                S_ERR: begin
                    r_error <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign mem_we       = r_we;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign prog_loading = r_loading;
    assign done         = r_done;
    assign error        = r_error;
    assign checksum     = r_checksum;

endmodule
`default_nettype wire
